// File: rtl/te_block_compressor.sv
// te_block_compressor: merges up to NRET retired uops per cycle into instruction blocks
// and queues completed blocks in a FIFO drained over a valid/ready stream.
module te_block_compressor #(
    parameter int NRET        = 2,
    parameter int XLEN        = 64,
    parameter int IRETIRE_LEN = 32,
    parameter int ITYPE_LEN   = 3,
    parameter int PRIV_LEN    = 2,
    parameter int DEPTH       = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NRET-1:0]           valid_i,
    input  logic [NRET*XLEN-1:0]      pc_i,
    input  logic [NRET*ITYPE_LEN-1:0] itype_i,
    input  logic [NRET-1:0]           compressed_i,
    input  logic [NRET*PRIV_LEN-1:0]  priv_i,
    output logic                      ready_o,
    input  logic                      flush_i,
    output logic                      block_valid_o,
    input  logic                      block_ready_i,
    output logic [XLEN-1:0]           block_iaddr_o,
    output logic [IRETIRE_LEN-1:0]    block_iretire_o,
    output logic [ITYPE_LEN-1:0]      block_itype_o,
    output logic [PRIV_LEN-1:0]       block_priv_o,
    output logic                      block_ilastsize_o,
    output logic [$clog2(DEPTH):0]    fifo_count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = $clog2(2*NRET + 2);
    localparam int SLOTS = 2**PW;
    localparam logic [ITYPE_LEN-1:0] STD = '0;
    localparam logic [IRETIRE_LEN:0] MAX_RET = {1'b0, {IRETIRE_LEN{1'b1}}};

    typedef struct packed {
        logic [XLEN-1:0]        iaddr;
        logic [IRETIRE_LEN-1:0] iretire;
        logic [ITYPE_LEN-1:0]   itype;
        logic [PRIV_LEN-1:0]    priv;
        logic                   ilastsize;
    } block_t;
    typedef enum logic {IDLE, COUNT} state_e;

    state_e state, st;
    block_t open_q, open_d, head;
    block_t mem [DEPTH];
    block_t pb [SLOTS];
    logic [PW-1:0] n;
    logic [AW-1:0] wptr, rptr;
    logic [AW:0] count;
    logic [IRETIRE_LEN-1:0] sz;
    logic pop;

    assign ready_o = count <= (AW+1)'(DEPTH - 2*NRET);
    assign pop = (count != '0) && block_ready_i;

    // Lanes walk the open block in program order; each may close it before and/or after itself.
    always_comb begin
        st = state;
        open_d = open_q;
        n = '0;
        sz = '0;
        for (int j = 0; j < SLOTS; j++) pb[j] = '0;
        for (int k = 0; k < NRET; k++) begin
            if (ready_o && valid_i[k]) begin
                sz = IRETIRE_LEN'(compressed_i[k] ? 1 : 2);
                if (st == COUNT && (priv_i[k*PRIV_LEN +: PRIV_LEN] != open_d.priv ||
                        {1'b0, open_d.iretire} + {1'b0, sz} > MAX_RET)) begin
                    pb[n] = open_d;
                    pb[n].itype = STD;
                    n = n + PW'(1);
                    st = IDLE;
                end
                if (st == IDLE) begin
                    open_d.iaddr = pc_i[k*XLEN +: XLEN];
                    open_d.iretire = sz;
                    open_d.priv = priv_i[k*PRIV_LEN +: PRIV_LEN];
                    st = COUNT;
                end else begin
                    open_d.iretire = open_d.iretire + sz;
                end
                open_d.ilastsize = compressed_i[k];
                if (itype_i[k*ITYPE_LEN +: ITYPE_LEN] != STD) begin
                    pb[n] = open_d;
                    pb[n].itype = itype_i[k*ITYPE_LEN +: ITYPE_LEN];
                    n = n + PW'(1);
                    st = IDLE;
                end
            end
        end
        if (flush_i && st == COUNT) begin
            pb[n] = open_d;
            pb[n].itype = STD;
            n = n + PW'(1);
            st = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            open_q <= '0;
            wptr   <= '0;
            rptr   <= '0;
            count  <= '0;
        end else begin
            state  <= st;
            open_q <= open_d;
            wptr   <= wptr + AW'(n);
            rptr   <= rptr + AW'(pop);
            count  <= count + (AW+1)'(n) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i)
            for (int j = 0; j < SLOTS; j++)
                if (PW'(j) < n) mem[wptr + AW'(j)] <= pb[j];
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) assert (int'(count) + int'(n) - int'(pop) <= DEPTH);
    end

    assign head = (count != '0) ? mem[rptr] : '0;
    assign block_valid_o     = count != '0;
    assign block_iaddr_o     = head.iaddr;
    assign block_iretire_o   = head.iretire;
    assign block_itype_o     = head.itype;
    assign block_priv_o      = head.priv;
    assign block_ilastsize_o = head.ilastsize;
    assign fifo_count_o      = count;
endmodule

// File: tb/tb_te_block_compressor.sv
// tb_te_block_compressor: directed vector table plus hand sequences for backpressure, reset and saturation.
module tb_te_block_compressor;
    localparam logic [2:0] STD = 3'd0, EXC = 3'd1, TB = 3'd5;

    logic        clk = 0, rst = 1, flush = 0, bready = 0;
    logic [1:0]  valid = 0, s_valid = 0, comp = 0;
    logic [63:0] pc = 0;
    logic [5:0]  itype = 0;
    logic [3:0]  priv = 0;
    logic        ready, bvalid, blast;
    logic [31:0] iaddr;
    logic [7:0]  iret;
    logic [2:0]  btype;
    logic [1:0]  bpriv;
    logic [3:0]  cnt;
    logic        s_ready, s_bvalid, s_blast;
    logic [31:0] s_iaddr;
    logic [3:0]  s_iret;
    logic [2:0]  s_btype;
    logic [1:0]  s_bpriv;
    logic [3:0]  s_cnt;
    int checks = 0, errors = 0;

    always #5 clk = ~clk;

    te_block_compressor #(.NRET(2), .XLEN(32), .IRETIRE_LEN(8), .DEPTH(8)) dut (
        .clk_i(clk), .rst_i(rst), .valid_i(valid), .pc_i(pc), .itype_i(itype),
        .compressed_i(comp), .priv_i(priv), .ready_o(ready), .flush_i(flush),
        .block_valid_o(bvalid), .block_ready_i(bready), .block_iaddr_o(iaddr),
        .block_iretire_o(iret), .block_itype_o(btype), .block_priv_o(bpriv),
        .block_ilastsize_o(blast), .fifo_count_o(cnt));

    te_block_compressor #(.NRET(2), .XLEN(32), .IRETIRE_LEN(4), .DEPTH(8)) sat (
        .clk_i(clk), .rst_i(rst), .valid_i(s_valid), .pc_i(pc), .itype_i(itype),
        .compressed_i(comp), .priv_i(priv), .ready_o(s_ready), .flush_i(flush),
        .block_valid_o(s_bvalid), .block_ready_i(bready), .block_iaddr_o(s_iaddr),
        .block_iretire_o(s_iret), .block_itype_o(s_btype), .block_priv_o(s_bpriv),
        .block_ilastsize_o(s_blast), .fifo_count_o(s_cnt));

    typedef struct {
        logic [1:0] v; logic [31:0] pc0, pc1; logic [2:0] t0, t1; logic [1:0] c;
        logic [1:0] p0, p1; logic fl, br;
        logic ev; logic [31:0] ea; logic [7:0] er; logic [2:0] et; logic el; logic [1:0] ep; int ec;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lanes(input logic [1:0] v, input logic [31:0] pc0, pc1, input logic [2:0] t0, t1,
                         input logic [1:0] c, p0, p1);
        valid = v; pc = {pc1, pc0}; itype = {t1, t0}; comp = c; priv = {p1, p0};
    endtask

    initial begin
        step();
        step();
        chk("rst valid", bvalid, 0);
        chk("rst count", cnt, 0);
        chk("rst ready", ready, 1);
        chk("rst iaddr", iaddr, 0);
        chk("rst iretire", iret, 0);
        chk("rst itype", btype, 0);
        chk("rst sat valid", s_bvalid, 0);
        rst = 0;

        tbl.push_back('{2'b11, 'h100, 'h104, STD, TB, 2'b10, 3, 3, 0, 1, 1, 'h100, 3, TB, 1, 3, 1});
        tbl.push_back('{2'b00, 0, 0, STD, STD, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0});
        for (int i = 0; i < 5; i++)
            tbl.push_back('{2'b11, 'h1d8 + 8*i, 'h1dc + 8*i, STD, STD, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{2'b01, 'h200, 0, EXC, STD, 0, 3, 3, 0, 0, 1, 'h1d8, 22, EXC, 0, 3, 1});
        tbl.push_back('{2'b00, 0, 0, STD, STD, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{2'b00, 0, 0, STD, STD, 0, 3, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{2'b11, 'h2f8, 'h2fc, STD, STD, 0, 3, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{2'b01, 'h300, 0, STD, STD, 0, 0, 3, 0, 0, 1, 'h2f8, 4, STD, 0, 3, 1});
        tbl.push_back('{2'b00, 0, 0, STD, STD, 0, 3, 3, 1, 1, 1, 'h300, 2, STD, 0, 0, 1});
        tbl.push_back('{2'b00, 0, 0, STD, STD, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{2'b01, 'h400, 0, STD, STD, 0, 3, 3, 1, 0, 1, 'h400, 2, STD, 0, 3, 1});
        tbl.push_back('{2'b00, 0, 0, STD, STD, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{2'b11, 'h500, 'h502, STD, EXC, 2'b01, 3, 1, 0, 0, 1, 'h500, 1, STD, 1, 3, 2});
        tbl.push_back('{2'b00, 0, 0, STD, STD, 0, 3, 3, 0, 1, 1, 'h502, 2, EXC, 0, 1, 1});
        tbl.push_back('{2'b00, 0, 0, STD, STD, 0, 3, 3, 0, 1, 0, 0, 0, 0, 0, 0, 0});

        foreach (tbl[i]) begin
            lanes(tbl[i].v, tbl[i].pc0, tbl[i].pc1, tbl[i].t0, tbl[i].t1, tbl[i].c, tbl[i].p0, tbl[i].p1);
            flush = tbl[i].fl;
            bready = tbl[i].br;
            step();
            chk($sformatf("row%0d valid", i), bvalid, tbl[i].ev);
            chk($sformatf("row%0d iaddr", i), iaddr, tbl[i].ea);
            chk($sformatf("row%0d iretire", i), iret, tbl[i].er);
            chk($sformatf("row%0d itype", i), btype, tbl[i].et);
            chk($sformatf("row%0d ilastsize", i), blast, tbl[i].el);
            chk($sformatf("row%0d priv", i), bpriv, tbl[i].ep);
            chk($sformatf("row%0d count", i), cnt, tbl[i].ec);
            chk($sformatf("row%0d ready", i), ready, tbl[i].ec <= 4);
        end
        flush = 0;
        bready = 0;

        // backpressure: one closing lane per cycle until ready drops, then hold
        for (int i = 0; i < 5; i++) begin
            lanes(2'b01, 'h600 + 4*i, 0, TB, STD, 0, 3, 3);
            step();
            chk($sformatf("bp count%0d", i), cnt, i + 1);
            chk($sformatf("bp ready%0d", i), ready, i < 4);
        end
        lanes(2'b01, 'h614, 0, TB, STD, 0, 3, 3);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("bp held count%0d", i), cnt, 5);
            chk($sformatf("bp held ready%0d", i), ready, 0);
        end
        lanes(0, 0, 0, STD, STD, 0, 3, 3);
        bready = 1;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drain iaddr%0d", i), iaddr, 'h600 + 4*i);
            chk($sformatf("drain itype%0d", i), btype, TB);
            step();
        end
        chk("drain count", cnt, 0);
        chk("drain ready", ready, 1);
        chk("drain valid", bvalid, 0);
        bready = 0;

        // reset with three blocks queued
        lanes(2'b11, 'h700, 'h704, TB, TB, 0, 3, 3);
        step();
        lanes(2'b01, 'h708, 0, TB, STD, 0, 3, 3);
        step();
        lanes(0, 0, 0, STD, STD, 0, 3, 3);
        chk("pre-rst count", cnt, 3);
        rst = 1;
        step();
        rst = 0;
        chk("mid rst valid", bvalid, 0);
        chk("mid rst count", cnt, 0);
        chk("mid rst ready", ready, 1);
        chk("mid rst iaddr", iaddr, 0);

        // iretire saturation on the 4-bit instance
        for (int i = 0; i < 4; i++) begin
            lanes(0, 'h800 + 8*i, 'h804 + 8*i, STD, STD, 0, 3, 3);
            s_valid = 2'b11;
            step();
        end
        s_valid = 0;
        chk("sat count", s_cnt, 1);
        chk("sat iaddr", s_iaddr, 'h800);
        chk("sat iretire", s_iret, 14);
        chk("sat itype", s_btype, STD);
        flush = 1;
        step();
        flush = 0;
        chk("sat flush count", s_cnt, 2);
        bready = 1;
        step();
        bready = 0;
        chk("sat second iaddr", s_iaddr, 'h81c);
        chk("sat second iretire", s_iret, 2);
        chk("sat second count", s_cnt, 1);
        chk("sat main untouched", cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/te_block_compressor.md
Name: te_block_compressor

Overview:
- Multi-port successor to the single-lane retirement counter (IDLE/COUNT) of the trace-encoder connector.
- Takes up to NRET retired uops per cycle from the CVA6 commit stage and merges runs of STD instructions into instruction blocks. Each block is one iaddr, one iretire halfword count and one closing itype.
- Completed blocks are buffered in an internal FIFO and drained over a valid/ready stream toward the encoder packetiser.

Parameters:
- NRET, 2, number of commit lanes per cycle (1..4); lane 0 is the oldest.
- XLEN, connector_pkg::XLEN, PC width.
- IRETIRE_LEN, connector_pkg::IRETIRE_LEN, iretire counter width.
- DEPTH, 8, output FIFO entries; must be >= 2*NRET and a power of two.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- valid_i  in  NRET  per-lane retire valid; set lanes are contiguous from lane 0
- pc_i  in  NRET*XLEN  per-lane PC
- itype_i  in  NRET*ITYPE_LEN  per-lane itype_e
- compressed_i  in  NRET  per-lane 16-bit instruction flag
- priv_i  in  NRET*PRIV_LEN  per-lane privilege
- ready_o  out  1  lanes accepted this cycle
- flush_i  in  1  force-close the open block
- block_valid_o  out  1  FIFO head valid
- block_ready_i  in  1  consumer takes the head
- block_iaddr_o  out  XLEN  first PC of the block
- block_iretire_o  out  IRETIRE_LEN  block size in halfwords
- block_itype_o  out  ITYPE_LEN  itype of the closing instruction (STD if closed without one)
- block_priv_o  out  PRIV_LEN  block privilege
- block_ilastsize_o  out  1  last instruction was compressed
- fifo_count_o  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset values:
  - state=IDLE, open-block registers and FIFO pointers cleared.
  - block_valid_o=0, fifo_count_o=0, all block_* outputs 0.
  - ready_o=1 (FIFO empty).
- Reset mid-operation discards the open block and all FIFO contents.
- Handshake:
  - ready_o = (DEPTH - count) >= 2*NRET. Combinational from registered count only; no dependence on valid_i.
  - Lanes are consumed only when ready_o=1. Upstream holds them otherwise.
  - Output pops when block_valid_o & block_ready_i.
- Per-instruction size: 1 halfword if compressed, else 2.
- Lanes are processed serially in one cycle, lane 0 first, against the running open block.
- IDLE, lane k valid:
  - Open a block: iaddr=pc, iretire=size, priv=priv.
  - Go to COUNT.
- COUNT, lane k valid, close-before rule:
  - Trigger: priv_k != open priv, or iretire+size > 2^IRETIRE_LEN-1.
  - Push the open block with itype=STD and ilastsize taken from the previous instruction.
  - Lane k then opens a new block.
- COUNT, lane k valid, otherwise: iretire += size; track ilastsize.
- Close-after rule (any state): if itype_k != STD, push the block containing lane k with itype=itype_k, then go to IDLE.
- Pushes per cycle: each lane can produce at most 2, so at most 2*NRET. The ready_o threshold guarantees no overflow.
- flush_i:
  - Evaluated after the lanes of the same cycle.
  - In COUNT, pushes the open block with itype=STD and goes to IDLE.
  - In IDLE, no effect.
- Push/pop ordering:
  - A push and a pop in the same cycle are both honoured.
  - The FIFO keeps program order: lower lane first, flush last.
- Latency: a block pushed in cycle t is visible on block_* in cycle t+1 if the FIFO was empty.
- Pop on empty is ignored. Push on full cannot occur; an assertion checks this.
- Pointers wrap modulo DEPTH.
- Holding block_ready_i=0 keeps block_* stable until the pop.

Test Plan:
- Single block: lane0 STD pc=0x100 (32b), lane1 TB pc=0x104 (compressed), block_ready_i=1 -> next cycle one block: iaddr=0x100, iretire=3, itype=TB, ilastsize=1.
- Multi-cycle accumulation: 5 cycles of 2 non-compressed STD lanes, then lane0 EXC pc=0x200 -> one block with iretire=22, itype=EXC; state returns to IDLE.
- Priv change: open block priv=3 iretire=4, lane0 STD priv=0 pc=0x300 -> block (iretire=4, STD, priv=3) pushed; new block opens with iaddr=0x300, priv=0.
- Saturation: IRETIRE_LEN=4, 8 non-compressed STD instructions -> first block iretire=14, STD; second block starts at the 8th PC.
- Backpressure: block_ready_i=0, DEPTH=8, NRET=2, five closing instructions -> ready_o drops once count>4; count never exceeds 8; draining restores ready_o with all blocks in order.
- Flush plus reset: flush_i with lane0 STD pc=0x400 -> block iaddr=0x400, iretire=2, STD. Then rst_i with 3 entries queued -> block_valid_o=0 and fifo_count_o=0 the next cycle.
